// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle computer: next-PC selector encodings,
// IFU state enum, default reset PC and the immediate sign-extension helper.
package sc_pkg;

    // Next-PC selector encodings, also driven by the control unit
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StValid = 2'b10
    } ifu_state_e;

    function automatic logic [31:0] sext32(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/sc_ifu_if.sv
// Fetch-unit bus: instruction-memory handshake plus the instruction/PC
// hand-off to the control unit and datapath. The master is the IFU.
interface sc_ifu_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        inst_done;
    logic [1:0]  pcsource;
    logic [31:0] rs_data;

    modport master (
        output imem_req, imem_addr, inst, inst_valid, pc, pc4,
        input  imem_ack, imem_rdata, inst_done, pcsource, rs_data
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_valid, pc, pc4,
        output imem_ack, imem_rdata, inst_done, pcsource, rs_data
    );
endinterface

// File: rtl/sc_npc.sv
// Combinational next-PC calculator, shared with the single-cycle datapath.
module sc_npc
    import sc_pkg::*;
(
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_rs_data,
    input  logic [1:0]  i_pcsource,
    output logic [31:0] o_npc
);

    logic [31:0] w_imm_ext;
    logic [31:0] w_br_target;
    logic [31:0] w_jr_target;
    logic [31:0] w_j_target;

    // Opcode bits and the low bits of the jr register never influence the PC
    logic w_unused_bits;
    assign w_unused_bits = ^{i_inst[31:26], i_rs_data[1:0]};

    // Branch, jr and jump targets, then select by pcsource
    always_comb begin
        w_imm_ext   = sext32(i_inst[15:0]);
        w_br_target = i_pc4 + {w_imm_ext[29:0], 2'b00};
        w_jr_target = {i_rs_data[31:2], 2'b00};
        w_j_target  = {i_pc4[31:28], i_inst[25:0], 2'b00};
        o_npc       = i_pc4;
        unique case (i_pcsource)
            PC_SEQ:  o_npc = i_pc4;
            PC_BR:   o_npc = w_br_target;
            PC_JR:   o_npc = w_jr_target;
            PC_J:    o_npc = w_j_target;
            default: o_npc = i_pc4;
        endcase
    end

endmodule

// File: rtl/sc_ifu.sv
// Instruction fetch unit: holds the PC, fetches over a req/ack handshake,
// presents the instruction until the core signals done, then moves to npc.
// Optional performance counters are built only when SC_IFU_PERF_EN is defined.
module sc_ifu
    import sc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clock,
    input  logic        i_reset,
    sc_ifu_if.master    bus,
    output logic [31:0] o_perf_retired,
    output logic [31:0] o_perf_stall
);

    ifu_state_e  r_state;
    ifu_state_e  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] w_pc4;
    logic [31:0] w_npc;
    logic        w_inst_load;
    logic        w_pc_load;
    logic        w_imem_req;
    logic        w_inst_valid;

    assign w_pc4 = r_pc + 32'd4;

    sc_npc u_npc (
        .i_pc4      (w_pc4),
        .i_inst     (r_inst),
        .i_rs_data  (bus.rs_data),
        .i_pcsource (bus.pcsource),
        .o_npc      (w_npc)
    );

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_inst_load  = 1'b0;
        w_pc_load    = 1'b0;
        w_imem_req   = 1'b0;
        w_inst_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_state_next = StFetch;
            end
            StFetch: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_inst_load  = 1'b1;
                    w_state_next = StValid;
                end
            end
            StValid: begin
                w_inst_valid = 1'b1;
                if (bus.inst_done) begin
                    w_pc_load    = 1'b1;
                    w_state_next = StFetch;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // PC and instruction holding registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc   <= RESET_PC;
            r_inst <= 32'h0000_0000;
        end else begin
            if (w_pc_load) begin
                r_pc <= w_npc;
            end
            if (w_inst_load) begin
                r_inst <= bus.imem_rdata;
            end
        end
    end

    assign bus.imem_req   = w_imem_req;
    assign bus.imem_addr  = r_pc;
    assign bus.inst       = r_inst;
    assign bus.inst_valid = w_inst_valid;
    assign bus.pc         = r_pc;
    assign bus.pc4        = w_pc4;

`ifdef SC_IFU_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall;

    // Retired-instruction and fetch-wait counters, wrapping modulo 2^32
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_perf_retired <= 32'h0;
            r_perf_stall   <= 32'h0;
        end else begin
            if (w_pc_load) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (r_state == StFetch && !bus.imem_ack) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_retired = r_perf_retired;
    assign o_perf_stall   = r_perf_stall;
`else
    assign o_perf_retired = 32'h0;
    assign o_perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_sc_ifu.sv
// Self-checking bench for sc_ifu: reset/first fetch, a table of fetch/retire
// vectors chained through every pcsource, then ignored-input and mid-fetch
// reset sequences. Perf expectations follow SC_IFU_PERF_EN.
module tb_sc_ifu;
    import sc_pkg::*;

`ifdef SC_IFU_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    sc_ifu_if bus ();

    sc_ifu #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .bus            (bus),
        .o_perf_retired (perf_retired),
        .o_perf_stall   (perf_stall)
    );

    typedef struct {
        logic [31:0] rdata;
        int          waits;
        logic [1:0]  src;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Wait (bounded) for a fetch request, sampling on negedges
    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.imem_req) chk({name, "_req_timeout"}, {31'b0, bus.imem_req}, 32'd1);
    endtask

    // Serve one fetch: check address, insert wait cycles, then ack
    task automatic fetch(input string name, input logic [31:0] exp_addr, input int waits,
                         input logic [31:0] rdata);
        wait_req(name);
        chk({name, "_addr"}, bus.imem_addr, exp_addr);
        repeat (waits) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hBAD0_BAD0;
        chk({name, "_valid"}, {31'b0, bus.inst_valid}, 32'd1);
        chk({name, "_inst"}, bus.inst, rdata);
    endtask

    // Pulse inst_done for one cycle with the given selector
    task automatic retire(input logic [1:0] src, input logic [31:0] rs);
        bus.inst_done = 1'b1;
        bus.pcsource  = src;
        bus.rs_data   = rs;
        @(negedge clk);
        bus.inst_done = 1'b0;
        bus.pcsource  = PC_J;
        bus.rs_data   = 32'h5A5A_5A5A;
    endtask

    initial begin
        vecs[0]  = '{32'h2008_0005, 3, PC_SEQ, 32'h0,         32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{32'h2009_000A, 3, PC_SEQ, 32'h0,         32'h0000_0004, 32'h0000_0008};
        vecs[2]  = '{32'h0109_5020, 3, PC_SEQ, 32'h0,         32'h0000_0008, 32'h0000_000C};
        vecs[3]  = '{32'hAC0A_0000, 3, PC_SEQ, 32'h0,         32'h0000_000C, 32'h0000_0010};
        vecs[4]  = '{32'h0100_0008, 0, PC_JR,  32'h0000_0043, 32'h0000_0010, 32'h0000_0040};
        vecs[5]  = '{32'h1109_FFFC, 1, PC_BR,  32'h0,         32'h0000_0040, 32'h0000_0034};
        vecs[6]  = '{32'h0100_0008, 2, PC_JR,  32'h1000_0000, 32'h0000_0034, 32'h1000_0000};
        vecs[7]  = '{32'h0800_0010, 0, PC_J,   32'h0,         32'h1000_0000, 32'h1000_0040};
        vecs[8]  = '{32'h03E0_0008, 1, PC_JR,  32'h0000_0123, 32'h1000_0040, 32'h0000_0120};
        vecs[9]  = '{32'h0100_0008, 0, PC_JR,  32'hFFFF_FFFF, 32'h0000_0120, 32'hFFFF_FFFC};
        vecs[10] = '{32'h0000_0000, 0, PC_SEQ, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000};
        vecs[11] = '{32'h0BFF_FFFF, 1, PC_J,   32'h0,         32'h0000_0000, 32'h0FFF_FFFC};
        vecs[12] = '{32'h1000_0001, 0, PC_BR,  32'h0,         32'h0FFF_FFFC, 32'h1000_0004};

        rst            = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.inst_done  = 1'b0;
        bus.pcsource   = PC_SEQ;
        bus.rs_data    = 32'h0;

        // Reset and first fetch with a zero-wait memory
        repeat (3) @(negedge clk);
        chk("rst_req",     {31'b0, bus.imem_req},   32'd0);
        chk("rst_valid",   {31'b0, bus.inst_valid}, 32'd0);
        chk("rst_pc",      bus.pc,   32'h0);
        chk("rst_pc4",     bus.pc4,  32'h4);
        chk("rst_inst",    bus.inst, 32'h0);
        chk("rst_retired", perf_retired, 32'h0);
        chk("rst_stall",   perf_stall,   32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'b0, bus.imem_req}, 32'd1);
        fetch("first", 32'h0, 0, 32'h2008_0005);

        // Reset again so the table starts with clean counters
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_valid", {31'b0, bus.inst_valid}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            fetch(nm, vecs[i].exp_pc, vecs[i].waits, vecs[i].rdata);
            chk({nm, "_pc"},  bus.pc,  vecs[i].exp_pc);
            chk({nm, "_pc4"}, bus.pc4, vecs[i].exp_pc + 32'd4);
            retire(vecs[i].src, vecs[i].rs);
            chk({nm, "_npc"}, bus.pc, vecs[i].exp_npc);
            chk({nm, "_refetch"}, {31'b0, bus.imem_req}, 32'd1);
            if (i == 3) begin
                chk("perf_retired", perf_retired, PerfEn ? 32'd4 : 32'd0);
                chk("perf_stall",   perf_stall,   PerfEn ? 32'd12 : 32'd0);
            end
        end

        // inst_done during FETCH and imem_ack during VALID are ignored
        wait_req("ign");
        bus.inst_done = 1'b1;
        bus.pcsource  = PC_J;
        bus.rs_data   = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.inst_done = 1'b0;
        chk("ign_done_pc",    bus.imem_addr, 32'h1000_0004);
        chk("ign_done_req",   {31'b0, bus.imem_req},   32'd1);
        chk("ign_done_valid", {31'b0, bus.inst_valid}, 32'd0);
        fetch("ign", 32'h1000_0004, 0, 32'hAAAA_5555);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("ign_ack_inst",  bus.inst, 32'hAAAA_5555);
        chk("ign_ack_valid", {31'b0, bus.inst_valid}, 32'd1);
        chk("ign_ack_pc",    bus.pc, 32'h1000_0004);

        // Reset while a fetch is outstanding, then a late ack in IDLE
        retire(PC_SEQ, 32'h0);
        wait_req("mid");
        chk("mid_addr", bus.imem_addr, 32'h1000_0008);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req",   {31'b0, bus.imem_req},   32'd0);
        chk("mid_rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        rst            = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("late_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("late_pc",    bus.pc,   32'h0);
        chk("late_inst",  bus.inst, 32'h0);
        chk("late_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("late_stall", perf_stall,   32'd0);
        chk("late_ret",   perf_retired, 32'd0);
        fetch("fresh", 32'h0, 1, 32'h2008_0005);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_ifu.md
# sc_ifu

Instruction fetch unit for the single-cycle computer. Holds the program counter, fetches each instruction from a wait-stated instruction memory over a request/acknowledge handshake, and presents it to the control unit and datapath. When the core signals completion, it computes the next PC from the 2-bit `pcsource` selector and starts the next fetch. It sits directly upstream of the control unit (`op` = `inst[31:26]`, `func` = `inst[5:0]`) and consumes that unit's `pcsource` output.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  fetch request; held until acknowledged.
- `imem_addr`  out  32  byte address of the fetch; always equals `pc`.
- `imem_ack`  in  1  `imem_rdata` valid this cycle; completes the request.
- `imem_rdata`  in  32  instruction word.
- `inst`  out  32  held instruction.
- `inst_valid`  out  1  `inst` is valid and being executed.
- `pc`  out  32  address of `inst`.
- `pc4`  out  32  `pc + 4`; used as the jal link value.
- `inst_done`  in  1  core finished `inst`; next PC is sampled this cycle.
- `pcsource`  in  2  next-PC selector.
- `rs_data`  in  32  register value used as the jr target.
- `perf_retired`  out  32  count of retired instructions (see Configuration).
- `perf_stall`  out  32  count of fetch-wait cycles (see Configuration).

## Operation
- FSM has three states: IDLE, FETCH, VALID.
- IDLE:
  - `imem_req` = 0, `inst_valid` = 0.
  - Always moves to FETCH on the next cycle.
- FETCH:
  - `imem_req` = 1, `imem_addr` = `pc`.
  - On `imem_ack`: `inst` <= `imem_rdata`, move to VALID.
- VALID:
  - `inst_valid` = 1.
  - On `inst_done`: `pc` <= `npc`, move to FETCH.
- Next-PC selection. Here `imm` = `inst[15:0]` and `idx` = `inst[25:0]`:
  - `pcsource` 00: `pc4`.
  - `pcsource` 01: `pc4 + (sext32(imm) << 2)` (taken branch).
  - `pcsource` 10: `{rs_data[31:2], 2'b00}` (jr).
  - `pcsource` 11: `{pc4[31:28], idx, 2'b00}` (j/jal).
- Arithmetic is modulo 2^32. `pc` = 32'hFFFF_FFFC with `pcsource` 00 wraps to 0.
- `pc[1:0]` is always 00. Low bits of `rs_data` are silently discarded.
- Ignored inputs:
  - `imem_ack` outside FETCH.
  - `inst_done` outside VALID.
  - `pcsource` and `rs_data` except in a cycle where `inst_done` is sampled in VALID.
- `imem_addr` and `imem_req` stay stable from request until ack; no cancellation.

## Timing
- Reset:
  - State IDLE, `pc` = `RESET_PC`, `inst` = 0.
  - `imem_req` = 0, `inst_valid` = 0.
  - `perf_*` = 0.
  - `pc4` = `RESET_PC` + 4.
- Cycle after reset deasserts: IDLE. Next cycle: FETCH with `imem_addr` = `RESET_PC`.
- Zero-wait memory (ack in the first FETCH cycle):
  - `inst_valid` rises the following cycle.
  - `inst_done` in that cycle gives FETCH of `npc` on the next cycle.
  - Minimum throughput is 2 cycles per instruction.
- N wait cycles add N cycles per instruction.
- `inst`, `pc`, `pc4`, `inst_valid` and `imem_req` are state-derived and do not change combinationally with inputs.
- Reset during FETCH (an outstanding request) or VALID: return to IDLE. A late `imem_ack` arriving in IDLE is dropped.
- `reset` overrides `inst_done` and `imem_ack` in the same cycle.

## Configuration
- `SC_IFU_PERF_EN` defined:
  - `perf_retired` increments on each accepted `inst_done` (VALID state).
  - `perf_stall` increments on each FETCH cycle without `imem_ack`.
  - Both wrap modulo 2^32 and are cleared by `reset`.
- `SC_IFU_PERF_EN` undefined: ports remain present, tied to 0, and no counter flops are built.

## Structure
- Shared package `sc_pkg`:
  - `pcsource` encodings: `PC_SEQ` = 2'b00, `PC_BR` = 2'b01, `PC_JR` = 2'b10, `PC_J` = 2'b11.
  - IFU state enum.
  - Default reset PC constant.
  - The control unit references the same encodings.
- Sub-module `sc_npc`: purely combinational next-PC calculator. Inputs `pc4`, `inst`, `rs_data`, `pcsource`; output `npc`. It is reused by the single-cycle datapath.

## Test plan
- **Reset and first fetch:** hold reset 3 cycles, release; memory acks immediately with 32'h2008_0005.
  - During reset: `imem_req` = 0, `pc` = 0.
  - FETCH begins 2 cycles after release with `imem_addr` = 0.
  - `inst` = 32'h2008_0005 and `inst_valid` = 1 one cycle later.
- **Sequential, wait states, perf counters:** 3 wait cycles per fetch, `pcsource` = 00, retire 4 instructions.
  - PCs: 0, 4, 8, C.
  - With `SC_IFU_PERF_EN`: `perf_stall` = 12, `perf_retired` = 4.
- **Taken branch:** `pc` = 32'h0000_0040, `inst` = 32'h1109_FFFC, `pcsource` = 01.
  - Next `imem_addr` = 32'h0000_0034.
- **Jump and jr:**
  - `pc` = 32'h1000_0000, `inst` = 32'h0800_0010, `pcsource` = 11: next `pc` = 32'h1000_0040.
  - `pcsource` = 10 with `rs_data` = 32'h0000_0123: next `pc` = 32'h0000_0120.
- **Wrap and ignored inputs:**
  - `pc` = 32'hFFFF_FFFC, `pcsource` = 00: next `pc` = 0.
  - `inst_done` pulsed during FETCH: no PC change.
- **Reset mid-fetch:** assert reset while FETCH is waiting, then ack one cycle later during IDLE.
  - `inst_valid` stays 0, `pc` = `RESET_PC`.
  - A fresh request is issued afterwards.
